microc_decode_checker: RTL
==========================

// Module: microc_decode_checker
// PURPOSE
//  Observer/checker for the microc datapath-control loop: the passive end of the unidadcontrol -> microc interface.
//  - Each clk it samples opcode and zero (datapath -> control) and s_inc, s_inm, we, wez, ALUOp (control -> datapath).
//  - Recomputes the decode, flags any mismatch and counts executed instruction classes.
//  - Sits beside the CPU in benches and FPGA debug builds; never drives the CPU.
// PARAMETERS
//  CNT_W        16  width of every counter and of err_cycle
//  SKIP_CYCLES  1   cycles ignored after entering RUN (PC/ROM settle), 0..15
//  STOP_ON_ERR  1   1: freeze in FAIL on first error; 0: log first error, keep checking
// PORTS
//  clk        in   1      rising-edge clock shared with microc/unidadcontrol
//  reset      in   1      asynchronous, active-high
//  enable     in   1      level; 1 = check/count, 0 = hold (IDLE)
//  clr        in   1      sync clear of counters and error state; wins over all same-cycle events
//  opcode     in   6      instruction opcode seen by the control unit
//  zero       in   1      ALU zero flag seen by the control unit
//  s_inc      in   1      PC mux select under test (1 = PC+1)
//  s_inm      in   1      ALU B-mux select under test (1 = immediate)
//  we         in   1      register-file write enable under test
//  wez        in   1      zero-flag write enable under test
//  alu_op     in   3      ALU operation under test
//  err        out  1      sticky: at least one error seen
//  err_code   out  2      00 none, 01 control mismatch, 10 illegal opcode
//  err_opcode out  6      opcode of the first error
//  err_cycle  out  CNT_W  cyc_cnt value at the first error
//  cyc_cnt    out  CNT_W  checked cycles
//  alu_cnt    out  CNT_W  ALU-class instructions (register and immediate)
//  jmp_cnt    out  CNT_W  jump-class instructions
//  taken_cnt  out  CNT_W  jumps with expected s_inc = 0
// BEHAVIOUR
//  Reset: state IDLE; every output and counter 0. Async assert; release is sampled on clk.
//  Decode table (expected values):
//   - opcode[5:4]=00, register ALU: alu_op=opcode[2:0], s_inc=1, s_inm=0, we=1, wez=1.
//   - opcode[5:4]=01, immediate ALU (LI/ADI/SBI): alu_op=opcode[2:0], s_inc=1, s_inm=1, we=1, wez=1.
//   - 6'b100000 J: s_inc=0, we=0, wez=0.
//   - 6'b100001 JZ: s_inc=~zero, we=0, wez=0.
//   - 6'b100010 JNZ: s_inc=zero, we=0, wez=0.
//   - Jumps: s_inm and alu_op are don't-care.
//   - Any other opcode is illegal.
//  FSM:
//   - IDLE -> SETTLE when enable=1.
//   - SETTLE counts SKIP_CYCLES, then -> RUN; SKIP_CYCLES=0 goes straight to RUN.
//   - RUN -> IDLE when enable=0.
//   - RUN -> FAIL on an error when STOP_ON_ERR=1.
//   - FAIL leaves only on reset or clr (-> IDLE).
//  Checking:
//   - In RUN, each edge compares the inputs with the decode table. Combinational compare, registered result: 1-cycle latency, so err rises on the edge after the offending sample.
//   - First error loads err_code/err_opcode/err_cycle. Later errors set nothing new.
//   - Illegal opcode has priority over mismatch in the same cycle.
//  Counters:
//   - Increment only in RUN, on a cycle with no error detected.
//   - Saturate at all-ones, no wrap.
//   - cyc_cnt counts every RUN cycle, errored ones included; err_cycle is its pre-increment value.
//  Boundary cases:
//   - enable dropped mid-RUN: counters and error state hold.
//   - clr during FAIL: zeroes everything, state -> IDLE.
//   - reset mid-RUN: immediate zeroing.
//   - X on an input in RUN is counted as a mismatch.
// STRUCTURE
//  Package microc_pkg:
//   - opcode class constants: OPC_CLASS_REG=2'b00, OPC_CLASS_IMM=2'b01, OPC_J, OPC_JZ, OPC_JNZ.
//   - ERR_NONE/ERR_MISMATCH/ERR_ILLEGAL.
//   - FSM state encoding.
//  Sub-module microc_ref_decode: combinational golden decode (opcode, zero -> expected controls, legal, don't-care mask). Reused by future unidadcontrol benches.
// TESTING
//  1. Reset, enable=1, SKIP_CYCLES=1, feed ADD (opcode 000000, alu_op 000, controls 1/0/1/1) x4 -> alu_cnt=4, cyc_cnt=4, err=0.
//  2. ADI opcode 010010 with s_inm=0 -> next edge: err=1, err_code=01, err_opcode=010010; FSM in FAIL, counters frozen.
//  3. JZ with zero=1, s_inc=0, then JNZ with zero=1, s_inc=1 -> jmp_cnt=2, taken_cnt=1, err=0.
//  4. Opcode 111111, STOP_ON_ERR=0 -> err_code=10. A later mismatch leaves err_code=10 and err_cycle unchanged; counting continues.
//  5. CNT_W=4, 20 ADDs -> alu_cnt=cyc_cnt=15 (saturated).
//  6. Error pending, then clr=1 for 1 cycle -> all outputs 0, IDLE. Reset asserted mid-RUN between edges -> outputs 0 before the next edge.

Source files
------------

// File: rtl/microc_pkg.sv
// Shared definitions for the microc control-loop checker: opcode classes,
// error codes, checker FSM states and the control bundle layout.
package microc_pkg;

    localparam logic [1:0] OPC_CLASS_REG = 2'b00;
    localparam logic [1:0] OPC_CLASS_IMM = 2'b01;
    localparam logic [5:0] OPC_J         = 6'b100000;
    localparam logic [5:0] OPC_JZ        = 6'b100001;
    localparam logic [5:0] OPC_JNZ       = 6'b100010;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISMATCH = 2'b01,
        ERR_ILLEGAL  = 2'b10
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_RUN    = 2'b10,
        ST_FAIL   = 2'b11
    } state_e;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/microc_ref_decode.sv
// Golden combinational decode of the microc control unit: expected controls,
// a care mask (jumps ignore s_inm/alu_op) and instruction class flags.
module microc_ref_decode
    import microc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    output ctrl_t      o_exp,
    output ctrl_t      o_care,
    output logic       o_legal,
    output logic       o_is_alu,
    output logic       o_is_jmp
);

    always_comb begin
        o_exp    = '0;
        o_care   = '0;
        o_legal  = 1'b0;
        o_is_alu = 1'b0;
        o_is_jmp = 1'b0;
        if (i_opcode[5:4] == OPC_CLASS_REG || i_opcode[5:4] == OPC_CLASS_IMM) begin
            o_legal      = 1'b1;
            o_is_alu     = 1'b1;
            o_exp.s_inc  = 1'b1;
            o_exp.s_inm  = (i_opcode[5:4] == OPC_CLASS_IMM);
            o_exp.we     = 1'b1;
            o_exp.wez    = 1'b1;
            o_exp.alu_op = i_opcode[2:0];
            o_care       = '1;
        end else begin
            case (i_opcode)
                OPC_J:   o_is_jmp = 1'b1;
                OPC_JZ:  begin o_is_jmp = 1'b1; o_exp.s_inc = ~i_zero; end
                OPC_JNZ: begin o_is_jmp = 1'b1; o_exp.s_inc = i_zero;  end
                default: ;
            endcase
            if (o_is_jmp) begin
                o_legal      = 1'b1;
                o_care.s_inc = 1'b1;
                o_care.we    = 1'b1;
                o_care.wez   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/microc_decode_checker.sv
// Passive checker beside the microc CPU: recomputes the control decode each
// cycle, latches the first error and counts executed instruction classes.
module microc_decode_checker
    import microc_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SKIP_CYCLES = 1,
    parameter bit          STOP_ON_ERR = 1'b1
)(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_clr,
    input  logic [5:0]       i_opcode,
    input  logic             i_zero,
    input  logic             i_s_inc,
    input  logic             i_s_inm,
    input  logic             i_we,
    input  logic             i_wez,
    input  logic [2:0]       i_alu_op,
    output logic             o_err,
    output logic [1:0]       o_err_code,
    output logic [5:0]       o_err_opcode,
    output logic [CNT_W-1:0] o_err_cycle,
    output logic [CNT_W-1:0] o_cyc_cnt,
    output logic [CNT_W-1:0] o_alu_cnt,
    output logic [CNT_W-1:0] o_jmp_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    localparam logic [3:0] SKIP_LAST = 4'(SKIP_CYCLES - 1);

    state_e           r_state;
    logic [3:0]       r_skip;
    logic             r_err;
    err_code_e        r_err_code;
    logic [5:0]       r_err_opcode;
    logic [CNT_W-1:0] r_err_cycle, r_cyc, r_alu, r_jmp, r_taken;

    ctrl_t w_act, w_exp, w_care;
    logic  w_legal, w_is_alu, w_is_jmp, w_mismatch, w_illegal, w_error;

    microc_ref_decode u_ref (
        .i_opcode (i_opcode),
        .i_zero   (i_zero),
        .o_exp    (w_exp),
        .o_care   (w_care),
        .o_legal  (w_legal),
        .o_is_alu (w_is_alu),
        .o_is_jmp (w_is_jmp)
    );

    assign w_act = '{s_inc: i_s_inc, s_inm: i_s_inm, we: i_we, wez: i_wez, alu_op: i_alu_op};

    // Default to mismatch so an unknown control bit falls through as an error.
    always_comb begin
        w_mismatch = 1'b1;
        if (((w_act ^ w_exp) & w_care) == '0) w_mismatch = 1'b0;
    end

    assign w_illegal = ~w_legal;
    assign w_error   = w_illegal | w_mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_skip       <= '0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_opcode <= '0;
            r_err_cycle  <= '0;
            r_cyc        <= '0;
            r_alu        <= '0;
            r_jmp        <= '0;
            r_taken      <= '0;
        end else if (i_clr) begin
            r_state      <= ST_IDLE;
            r_skip       <= '0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_opcode <= '0;
            r_err_cycle  <= '0;
            r_cyc        <= '0;
            r_alu        <= '0;
            r_jmp        <= '0;
            r_taken      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_enable) begin
                    r_skip  <= '0;
                    r_state <= (SKIP_CYCLES == 0) ? ST_RUN : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!i_enable)               r_state <= ST_IDLE;
                    else if (r_skip == SKIP_LAST) r_state <= ST_RUN;
                    else                          r_skip  <= r_skip + 4'd1;
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cyc <= sat_inc(r_cyc);
                        if (w_error) begin
                            if (!r_err) begin
                                r_err        <= 1'b1;
                                r_err_code   <= w_illegal ? ERR_ILLEGAL : ERR_MISMATCH;
                                r_err_opcode <= i_opcode;
                                r_err_cycle  <= r_cyc;
                            end
                            if (STOP_ON_ERR) r_state <= ST_FAIL;
                        end else begin
                            if (w_is_alu) r_alu <= sat_inc(r_alu);
                            if (w_is_jmp) r_jmp <= sat_inc(r_jmp);
                            if (w_is_jmp && !w_exp.s_inc) r_taken <= sat_inc(r_taken);
                        end
                    end
                end
                ST_FAIL: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    assign o_err_opcode = r_err_opcode;
    assign o_err_cycle  = r_err_cycle;
    assign o_cyc_cnt    = r_cyc;
    assign o_alu_cnt    = r_alu;
    assign o_jmp_cnt    = r_jmp;
    assign o_taken_cnt  = r_taken;

endmodule
